// File: rtl/mealy_pkg.sv
// Shared constants, action encoding and prefix/border match helpers for the
// parametrised Mealy sequence detector (used by RTL; available to benches).
package mealy_pkg;

  localparam int MAX_LEN   = 16;
  localparam int LEN_DEF   = 4;
  localparam int CNT_W_DEF = 8;
  localparam logic [MAX_LEN-1:0] PAT_RST_DEF = 16'h000B;

  typedef enum logic [1:0] {
    ACT_IDLE  = 2'd0,
    ACT_SHIFT = 2'd1,
    ACT_LOAD  = 2'd2
  } act_e;

  // Pattern bits are stored MSB-first: pattern position p lives at pat[len-1-p].
  function automatic logic pat_bit(input logic [MAX_LEN-1:0] pat, input int idx);
    logic [MAX_LEN-1:0] sh;
    sh = pat >> idx;
    return sh[0];
  endfunction

  // Bit p of the candidate string: first k pattern bits followed by x.
  function automatic logic cand_bit(input logic [MAX_LEN-1:0] pat, input int len,
                                    input int k, input logic x, input int p);
    logic b;
    if (p < k) b = pat_bit(pat, len - 1 - p);
    else       b = x;
    return b;
  endfunction

  // Largest j <= k+1 such that the last j candidate bits equal the first j pattern bits.
  function automatic int pfx_match(input logic [MAX_LEN-1:0] pat, input int len,
                                   input int k, input logic x);
    int   best;
    logic ok;
    best = 0;
    for (int j = 1; j <= MAX_LEN; j++) begin
      if (j <= k + 1 && j <= len) begin
        ok = 1'b1;
        for (int m = 0; m < MAX_LEN; m++) begin
          if (m < j) begin
            if (cand_bit(pat, len, k, x, k + 1 - j + m) != pat_bit(pat, len - 1 - m))
              ok = 1'b0;
          end
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  // Longest proper border: largest b < len where the first b bits equal the last b bits.
  function automatic int border_len(input logic [MAX_LEN-1:0] pat, input int len);
    int   best;
    logic ok;
    best = 0;
    for (int b = 1; b < MAX_LEN; b++) begin
      if (b < len) begin
        ok = 1'b1;
        for (int m = 0; m < MAX_LEN; m++) begin
          if (m < b) begin
            if (pat_bit(pat, len - 1 - m) != pat_bit(pat, b - 1 - m))
              ok = 1'b0;
          end
        end
        if (ok) best = b;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/mealy_next_state.sv
// Combinational next-prefix-length and match flag for the sequence detector.
module mealy_next_state
  import mealy_pkg::*;
#(
  parameter int LEN = LEN_DEF,
  parameter int SW  = $clog2(LEN)
) (
  input  logic [SW-1:0]  k,
  input  logic           x_in,
  input  logic [LEN-1:0] pat,
  input  logic           overlap_en,
  output logic [SW-1:0]  next_k,
  output logic           match
);

  logic [MAX_LEN-1:0] pat_ext;
  int                 j;

  assign pat_ext = MAX_LEN'(pat);

  always_comb begin
    j      = pfx_match(pat_ext, LEN, int'(k), x_in);
    match  = (j == LEN);
    next_k = SW'(j);
    // A full match restarts from the pattern's border (overlap) or from scratch.
    if (match) begin
      if (overlap_en) next_k = SW'(border_len(pat_ext, LEN));
      else            next_k = '0;
    end
  end

endmodule

// File: rtl/mealy_seq_detector.sv
// Parametrised Mealy serial sequence detector with runtime-loadable pattern.
// Optional saturating match counter enabled by defining MEALY_MATCH_CNT_EN.
module mealy_seq_detector
  import mealy_pkg::*;
#(
  parameter int             LEN     = LEN_DEF,
  parameter logic [LEN-1:0] PAT_RST = PAT_RST_DEF[LEN-1:0],
  parameter int             CNT_W   = CNT_W_DEF,
  localparam int            SW      = $clog2(LEN)
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             xIn,
  input  logic             xValid,
  input  logic             patLoad,
  input  logic [LEN-1:0]   patIn,
  input  logic             overlapEn,
  output logic             z,
  output logic [SW-1:0]    state,
  output logic [SW-1:0]    nextState,
  output logic [CNT_W-1:0] matchCnt
);

  logic [SW-1:0]  state_q, state_d;
  logic [LEN-1:0] pat_q, pat_d;
  logic [SW-1:0]  ns_k;
  logic           ns_match;
  logic           z_d;
  act_e           act;

  mealy_next_state #(.LEN(LEN), .SW(SW)) u_next_state (
    .k          (state_q),
    .x_in       (xIn),
    .pat        (pat_q),
    .overlap_en (overlapEn),
    .next_k     (ns_k),
    .match      (ns_match)
  );

  // Load has priority over a qualified bit; the loaded pattern applies from the next bit.
  always_comb begin
    act     = ACT_IDLE;
    state_d = state_q;
    pat_d   = pat_q;
    z_d     = 1'b0;
    if (patLoad)     act = ACT_LOAD;
    else if (xValid) act = ACT_SHIFT;
    case (act)
      ACT_LOAD: begin
        pat_d   = patIn;
        state_d = '0;
      end
      ACT_SHIFT: begin
        state_d = ns_k;
        z_d     = ns_match;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= '0;
      pat_q   <= PAT_RST;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
    end
  end

  assign z         = z_d;
  assign state     = state_q;
  assign nextState = state_d;

`ifdef MEALY_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (z_d && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign matchCnt = cnt_q;
`else
  assign matchCnt = '0;
`endif

endmodule

// File: doc/mealy_seq_detector.md
# mealy_seq_detector

Parametrised Mealy-type serial sequence detector; next generation of the team's fixed 4-state Mealy FSM. Tracks the longest matched prefix of a runtime-loadable pattern of `LEN` bits against a qualified serial input stream. Asserts a combinational Mealy output on the completing bit, with selectable overlapping or non-overlapping detection. Sits behind any serial bit source in the lab designs; exposes state and next state for waveform inspection.

## Interface
- `LEN`, 4: pattern length in bits; legal range 2..16.
- `PAT_RST`, 4'b1011: pattern value loaded at reset; width `LEN`.
- `CNT_W`, 8: match counter width.
- `SW`, derived `$clog2(LEN)`: state width; not overridden.

- `clk`  in  1  clock; all state updates on rising edge.
- `rstN`  in  1  reset, asynchronous, active-low.
- `xIn`  in  1  serial data bit.
- `xValid`  in  1  qualifies `xIn`; state advances only when high.
- `patLoad`  in  1  load `patIn` into the pattern register.
- `patIn`  in  `LEN`  new pattern; bit `LEN-1` is the first expected bit.
- `overlapEn`  in  1  1 = overlapping detection, 0 = non-overlapping.
- `z`  out  1  Mealy match output, combinational.
- `state`  out  `SW`  current matched-prefix length k, 0..LEN-1.
- `nextState`  out  `SW`  combinational next k.
- `matchCnt`  out  `CNT_W`  saturating count of matches (see Configuration).

## Operation
- State k = number of pattern bits currently matched, MSB-first; legal 0..LEN-1.
- On `xValid` and no `patLoad`: form candidate string = first k pattern bits followed by `xIn`. `nextState` = largest j ≤ k+1 such that the last j candidate bits equal the first j pattern bits.
- If j == LEN: `z` = 1. `nextState` = longest proper border of the pattern when `overlapEn` = 1, else 0.
- `z` = `xValid` & ~`patLoad` & (k == LEN-1) & (`xIn` == pattern bit 0). Depends on current `xIn`; no registering.
- `xValid` = 0: `nextState` = `state`, `z` = 0.
- `patLoad` = 1: pattern register takes `patIn`, state forced to 0, `z` = 0, `xIn` ignored. This takes priority over `xValid`.
- `overlapEn` is sampled only on the completing bit; it may change at any time.
- Reset values: state 0, pattern `PAT_RST`, `matchCnt` 0. `z` and `nextState` follow combinationally: with `xValid` low, both are 0.

## Timing
- `z` is valid in the same cycle as the completing `xIn`. Zero latency, Mealy.
- `state` updates on the rising `clk` edge after a qualified bit. Detection latency is `LEN` qualified bits from a clean start.
- A new pattern is effective for the first qualified bit after the load edge.
- Reset asserted mid-sequence clears state and counter immediately, without waiting for a clock. The first qualified bit after `rstN` rises is bit 0 of a new sequence.
- `matchCnt` increments on the edge that ends a `z` = 1 cycle. It holds at all-ones and never wraps.

## Configuration
- `MEALY_MATCH_CNT_EN` defined: `matchCnt` register and increment logic are present as described.
- Not defined: `matchCnt` is tied to 0 and no counter flops are generated. The port remains, so benches compile unchanged.

## Structure
- Package `mealy_pkg`: default `LEN`/`PAT_RST`/`CNT_W`, a `MAX_LEN` = 16 constant, and the prefix-suffix match function shared by RTL and the bench reference model.
- Sub-module `mealy_next_state`: pure combinational block computing `nextState` and the raw match flag from k, `xIn`, pattern and `overlapEn`. The top holds the registers, the load/valid priority and the counter.

## Test plan
- Reset, pattern 1011, overlap 1, stream 1,0,1,1 → `z` = 1 on the 4th bit only; state sequence 0,1,2,3,1.
- Overlap 1, stream 1,0,1,1,0,1,1 → `z` = 1 on bits 4 and 7; `matchCnt` = 2.
- Overlap 0, same stream → `z` = 1 on bit 4 only; state returns to 0 after the match; `matchCnt` = 1.
- Partial 1,0,1, then `xValid` low 3 cycles, then 1 → state holds at 3, `z` = 1 on the resumed bit.
- `patLoad` with `patIn` = 0110 asserted together with `xValid`, `xIn` = 1 → `z` = 0, state 0. Stream 0,1,1,0 then gives `z` = 1 on the 4th bit.
- Assert `rstN` low at state 2 between clock edges → state, `matchCnt` go 0 immediately; pattern returns to 1011. With `CNT_W` = 2 and 5 matches, `matchCnt` saturates at 3.
